// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the mem_responder slice.
//   state_t    : responder FSM states (IDLE / WAIT / RESP)
//   LFSR_SEED  : value the stall LFSR takes on reset
//   LFSR_TAPS  : feedback mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
//   CNT_W      : width of the LATENCY field (0..15)
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int         CNT_W     = 4;

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Advances every cycle; reloads LFSR_SEED on reset.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   state  out  current 8-bit LFSR state
module lfsr8
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (reset) state <= LFSR_SEED;
        else       state <= {state[6:0], ^(state & LFSR_TAPS)};
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-port word-addressed memory on a picorv32-style bus.
// A request seen in IDLE is latched, waits LATENCY (+ optional stall) cycles,
// then completes with a one-cycle mem_ready. Out-of-range accesses read 0,
// drop writes and raise mem_err alongside mem_ready.
// Optional feature: define MEM_RANDOM_STALL_EN to add 0..3 pseudo-random
// wait cycles per request, taken from an lfsr8 instance.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   mem_valid, mem_instr request pending / instruction fetch (no effect)
//   mem_addr, mem_wdata  byte address ([1:0] ignored), write data
//   mem_wstrb            byte enables, 0 = read
//   mem_ready, mem_rdata completion pulse, read data (0 on writes)
//   mem_err              out-of-range flag, pulses with mem_ready
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    state_t         state, state_nxt;
    // One bit wider than CNT_W so LATENCY plus a 0..3 stall never wraps.
    logic [CNT_W:0] cnt, cnt_nxt, cnt_load;
    logic [31:0]    addr_q, wdata_q;
    logic [3:0]     wstrb_q;
    logic           skip_q;
    logic           accept;
    logic [1:0]     stall;

    logic [31:0]    cur_addr, off;
    logic [3:0]     cur_wstrb;
    logic           in_range;
    logic [AW-1:0]  idx;

    logic [31:0]    mem [DEPTH_WORDS];

`ifdef MEM_RANDOM_STALL_EN
    logic [7:0] lfsr;
    logic       unused_lfsr;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr)
    );

    assign stall       = lfsr[1:0];
    assign unused_lfsr = ^lfsr[7:2];
`else
    assign stall = 2'd0;
`endif

    // The cycle after RESP the initiator is still dropping mem_valid.
    assign accept   = (state == IDLE) && mem_valid && !skip_q;
    assign cnt_load = (CNT_W+1)'(LATENCY) + {{(CNT_W-1){1'b0}}, stall};

    // With zero latency RESP is entered on the accept edge, before the
    // request registers hold the new request, so decode from the bus then.
    assign cur_addr  = (state == IDLE) ? mem_addr  : addr_q;
    assign cur_wstrb = (state == IDLE) ? mem_wstrb : wstrb_q;
    assign off       = cur_addr - BASE_ADDR;
    assign in_range  = (cur_addr >= BASE_ADDR) && (off < SPAN);
    assign idx       = off[AW+1:2];

    logic unused_bits;
    assign unused_bits = ^{mem_instr, off[1:0], off[31:AW+2]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                if (cnt_load == '0) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = cnt_load;
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == (CNT_W+1)'(1)) begin
                    state_nxt = RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - (CNT_W+1)'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            skip_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            skip_q    <= (state == RESP);
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            mem_ready <= (state_nxt == RESP);
            mem_err   <= (state_nxt == RESP) && !in_range;
            mem_rdata <= ((state_nxt == RESP) && (cur_wstrb == 4'b0000) && in_range)
                         ? mem[idx] : 32'h0;
        end
    end

    // Write commits on the edge that ends RESP; a reset on that edge wins.
    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: u_dut1 has LATENCY=1, u_dut0 LATENCY=0.
// Default build checks exact latencies; with MEM_RANDOM_STALL_EN it checks
// u_dut0 latencies against a reference LFSR model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst1, v1, ins1, rdy1, err1;
    logic [31:0] a1, wd1, rd1;
    logic [3:0]  ws1;
    logic        rst0, v0, ins0, rdy0, err0;
    logic [31:0] a0, wd0, rd0;
    logic [3:0]  ws0;
    logic [7:0]  lfsr_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .reset(rst1), .mem_valid(v1), .mem_instr(ins1), .mem_ready(rdy1),
        .mem_addr(a1), .mem_wdata(wd1), .mem_wstrb(ws1), .mem_rdata(rd1), .mem_err(err1)
    );

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(rst0), .mem_valid(v0), .mem_instr(ins0), .mem_ready(rdy0),
        .mem_addr(a0), .mem_wdata(wd0), .mem_wstrb(ws0), .mem_rdata(rd0), .mem_err(err0)
    );

    // Reference x^8+x^6+x^5+x^4+1 Fibonacci LFSR tracking u_dut0's reset.
    always @(posedge clk) begin
        if (rst0) lfsr_m <= 8'hA5;
        else      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction; lat counts edges from the accept edge to mem_ready.
    task automatic xact(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata,
                        output logic err, output int lat, output logic [7:0] snap);
        bit got = 0;
        repeat (2) @(posedge clk);
        #1;
        if (sel) begin v1 = 1'b1; a1 = addr; wd1 = wdata; ws1 = wstrb; end
        else     begin v0 = 1'b1; a0 = addr; wd0 = wdata; ws0 = wstrb; end
        snap  = lfsr_m;
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel ? rdy1 : rdy0) begin
                got   = 1;
                rdata = sel ? rd1 : rd0;
                err   = sel ? err1 : err0;
            end
        end
        if (sel) v1 = 1'b0; else v0 = 1'b0;
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk);
            #1;
            chk("ready_one_cycle", 32'(sel ? rdy1 : rdy0), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [7:0]  snap;

        rst1 = 1'b1; v1 = 1'b0; ins1 = 1'b0; a1 = '0; wd1 = '0; ws1 = '0;
        rst0 = 1'b1; v0 = 1'b0; ins0 = 1'b0; a0 = '0; wd0 = '0; ws0 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready1", 32'(rdy1), 32'd0);
        chk("rst_err1",   32'(err1), 32'd0);
        chk("rst_rdata1", rd1,       32'h0);
        chk("rst_ready0", 32'(rdy0), 32'd0);
        chk("rst_rdata0", rd0,       32'h0);
        rst1 = 1'b0;
        rst0 = 1'b0;

        // Write then read, LATENCY=1.
        xact(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, snap);
        chk("wr_rdata", rd, 32'h0);
        chk("wr_err", 32'(er), 32'd0);
`ifndef MEM_RANDOM_STALL_EN
        chk("wr_lat", lat, 2);
`endif
        xact(1, 32'h10, 32'h0, 4'h0, rd, er, lat, snap);
        chk("rd_data", rd, 32'hDEADBEEF);
`ifndef MEM_RANDOM_STALL_EN
        chk("rd_lat", lat, 2);
`endif

        // Byte strobes.
        xact(1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, snap);
        xact(1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, snap);
        xact(1, 32'h20, 32'h0, 4'h0, rd, er, lat, snap);
        chk("strobe_merge", rd, 32'h11BB33DD);

        // Out of range: 0x1000 is word 1024, one past the end.
        xact(1, 32'h0, 32'h12345678, 4'hF, rd, er, lat, snap);
        xact(1, 32'h1000, 32'h0, 4'h0, rd, er, lat, snap);
        chk("oor_rd_data", rd, 32'h0);
        chk("oor_rd_err", 32'(er), 32'd1);
        xact(1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat, snap);
        chk("oor_wr_err", 32'(er), 32'd1);
        xact(1, 32'h0, 32'h0, 4'h0, rd, er, lat, snap);
        chk("oor_word0_kept", rd, 32'h12345678);
        chk("inr_err", 32'(er), 32'd0);

        // Reset during WAIT discards a pending write.
        xact(1, 32'h30, 32'h0BADF00D, 4'hF, rd, er, lat, snap);
        repeat (2) @(posedge clk);
        #1;
        v1 = 1'b1; a1 = 32'h30; wd1 = 32'hFFFF0000; ws1 = 4'hF;
        @(posedge clk);
        #1;
        chk("midwait_no_ready", 32'(rdy1), 32'd0);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 32'(rdy1), 32'd0);
        chk("midrst_err",   32'(err1), 32'd0);
        chk("midrst_rdata", rd1,       32'h0);
        rst1 = 1'b0;
        v1   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midrst_still_quiet", 32'(rdy1), 32'd0);
        end
        xact(1, 32'h30, 32'h0, 4'h0, rd, er, lat, snap);
        chk("midrst_old_value", rd, 32'h0BADF00D);

`ifndef MEM_RANDOM_STALL_EN
        // LATENCY=0.
        xact(0, 32'h40, 32'hCAFEF00D, 4'hF, rd, er, lat, snap);
        chk("lat0_wr_lat", lat, 1);
        xact(0, 32'h40, 32'h0, 4'h0, rd, er, lat, snap);
        chk("lat0_rd_lat", lat, 1);
        chk("lat0_rd_data", rd, 32'hCAFEF00D);

        // mem_valid held high: accept, RESP, ignored cycle, accept, ...
        repeat (2) @(posedge clk);
        #1;
        v0 = 1'b1; a0 = 32'h40; ws0 = 4'h0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", 32'(rdy0), 32'((k % 3) == 1));
        end
        v0 = 1'b0;
`else
        // Random stalls on u_dut0 from a fresh reset.
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            xact(0, 32'h40, 32'h0, 4'h0, rd, er, lat, snap);
            chk("stall_lat_model", lat, 1 + int'(snap[1:0]));
            chk("stall_lat_range", 32'(lat >= 1 && lat <= 4), 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
